// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipeline step controller: controller states,
// host command codes and the halt instruction pattern.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } step_state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_PAUSE = 2'b11
  } step_cmd_e;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_step_controller.sv
// Run/step/halt controller that gates the pipeline stall and counts unstalled cycles.
// Define STEP_CTRL_CYCLE_CNT_EN to build the cycle counter; otherwise o_cycle_count is tied to 0.
//
// state  | meaning
// IDLE   | pipeline stalled, waiting for RUN or STEP
// RUN    | free-running until PAUSE or a halt instruction
// STEP   | exactly one unstalled cycle, then back to IDLE
// DRAIN  | halt fetched; let in-flight instructions retire
// HALTED | stalled for good, only reset leaves
module pipeline_step_controller
  import mips_ctrl_pkg::*;
#(
  parameter int SIZE         = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic [SIZE-1:0]      i_instruction,
  input  logic                 i_clear_count,
  output logic                 o_stall,
  output logic [2:0]           o_state,
  output logic                 o_done,
  output logic                 o_halted,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  step_state_e        state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               cmd_acc;
  logic               halt_seen;
  step_cmd_e          cmd;

  assign cmd       = step_cmd_e'(i_cmd);
  assign cmd_acc   = i_cmd_valid && o_cmd_ready;
  assign halt_seen = (i_instruction == SIZE'(HALT_INSTR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    o_done      = 1'b0;
    o_stall     = 1'b1;
    o_cmd_ready = 1'b0;
    o_halted    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          if (cmd == CMD_RUN)       state_d = ST_RUN;
          else if (cmd == CMD_STEP) state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        o_stall     = 1'b0;
        o_cmd_ready = 1'b1;
        // A halt wins over a PAUSE presented in the same cycle.
        if (halt_seen) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cmd_acc && cmd == CMD_PAUSE) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        o_stall = 1'b0;
        if (halt_seen) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
          o_done  = 1'b1;
        end
      end
      ST_DRAIN: begin
        o_stall = 1'b0;
        if (drain_q == '0) begin
          state_d = ST_HALTED;
          o_done  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_state = state_q;

`ifdef STEP_CTRL_CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else if (i_clear_count) begin
      cycle_cnt_q <= '0;
    end else if (!o_stall && !(&cycle_cnt_q)) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_cycle_count = cycle_cnt_q;
`else
  logic unused_clear_count;

  assign unused_clear_count = i_clear_count;
  assign o_cycle_count      = '0;
`endif

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Directed bench for pipeline_step_controller: step, run/pause, halt drain,
// halt vs pause priority, async reset mid-drain and counter saturation.
module tb_pipeline_step_controller;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [31:0] instr;
  logic        clr;

  logic        ready, stall, done, halted;
  logic [2:0]  state;
  logic [31:0] cnt;
  logic        ready4, stall4, done4, halted4;
  logic [2:0]  state4;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_err = 0;
  int low_cycles;

  always #5 clk = ~clk;

  pipeline_step_controller #(.SIZE(32), .DRAIN_CYCLES(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(ready),
    .i_instruction(instr), .i_clear_count(clr), .o_stall(stall), .o_state(state),
    .o_done(done), .o_halted(halted), .o_cycle_count(cnt)
  );

  pipeline_step_controller #(.SIZE(32), .DRAIN_CYCLES(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(ready4),
    .i_instruction(instr), .i_clear_count(clr), .o_stall(stall4), .o_state(state4),
    .o_done(done4), .o_halted(halted4), .o_cycle_count(cnt4)
  );

  // Expected counter value: the counter only exists when the macro is defined.
  function automatic logic [31:0] ec(input int v);
`ifdef STEP_CTRL_CYCLE_CNT_EN
    return 32'(v);
`else
    return (v > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] ins, input logic cl);
    cmd_valid = v;
    cmd       = c;
    instr     = ins;
    clr       = cl;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_state",  32'(state),  32'(ST_IDLE));
    check("rst_stall",  32'(stall),  32'd1);
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_done",   32'(done),   32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cnt",    cnt,         32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold_stall", 32'(stall), 32'd1);

    // single step
    drive(1'b1, CMD_STEP, 32'd0, 1'b0);
    check("step_acc_stall", 32'(stall), 32'd1);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    check("step_state", 32'(state), 32'(ST_STEP));
    check("step_stall", 32'(stall), 32'd0);
    check("step_done",  32'(done),  32'd1);
    check("step_ready", 32'(ready), 32'd0);
    @(negedge clk);
    check("step_back_idle",  32'(state), 32'(ST_IDLE));
    check("step_back_stall", 32'(stall), 32'd1);
    check("step_back_done",  32'(done),  32'd0);
    check("step_cnt",        cnt,        ec(1));

    // run ten cycles then pause, with a STEP ignored in between
    drive(1'b1, CMD_RUN, 32'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    low_cycles = 0;
    for (int i = 1; i <= 10; i++) begin
      if (!stall) low_cycles++;
      if (i == 3) drive(1'b1, CMD_STEP, 32'd0, 1'b0);
      if (i == 4) begin
        check("run_ignore_step", 32'(state), 32'(ST_RUN));
        drive(1'b0, CMD_NOP, 32'd0, 1'b0);
      end
      if (i == 10) drive(1'b1, CMD_PAUSE, 32'd0, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    check("pause_state",      32'(state),       32'(ST_IDLE));
    check("pause_stall",      32'(stall),       32'd1);
    check("run_low_cycles",   32'(low_cycles),  32'd10);
    check("run_cnt",          cnt,              ec(10));
    check("run_cnt4",         32'(cnt4),        ec(10));

    // halt at the fifth run cycle, drain four cycles, then HALTED
    drive(1'b1, CMD_RUN, 32'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    drive(1'b0, CMD_NOP, HALT_INSTR, 1'b0);
    check("halt_fetch_state", 32'(state), 32'(ST_RUN));
    check("halt_fetch_done",  32'(done),  32'd0);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    for (int d = 1; d <= 4; d++) begin
      if (d == 2) drive(1'b1, CMD_RUN, 32'd0, 1'b0);
      if (d == 3) drive(1'b0, CMD_NOP, 32'd0, 1'b0);
      check($sformatf("drain%0d_state", d), 32'(state), 32'(ST_DRAIN));
      check($sformatf("drain%0d_stall", d), 32'(stall), 32'd0);
      check($sformatf("drain%0d_ready", d), 32'(ready), 32'd0);
      check($sformatf("drain%0d_done", d),  32'(done),  (d == 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("halted_state",  32'(state),  32'(ST_HALTED));
    check("halted_flag",   32'(halted), 32'd1);
    check("halted_stall",  32'(stall),  32'd1);
    check("halted_ready",  32'(ready),  32'd0);
    check("halted_done",   32'(done),   32'd0);
    check("halted_cnt",    cnt,         ec(9));
    drive(1'b1, CMD_RUN, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    check("halted_ignore_run", 32'(state), 32'(ST_HALTED));

    // reset out of HALTED, then HALT and PAUSE together
    rst = 1'b1;
    #1;
    check("halted_rst_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, CMD_RUN, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, CMD_PAUSE, HALT_INSTR, 1'b0);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    check("halt_vs_pause", 32'(state), 32'(ST_DRAIN));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_drain_rst_state",  32'(state),  32'(ST_IDLE));
    check("mid_drain_rst_stall",  32'(stall),  32'd1);
    check("mid_drain_rst_cnt",    cnt,         32'd0);
    check("mid_drain_rst_done",   32'(done),   32'd0);
    check("mid_drain_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // saturation of the narrow counter and clear while running
    drive(1'b1, CMD_RUN, 32'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    repeat (20) @(negedge clk);
    check("sat_cnt32", cnt,        ec(20));
    check("sat_cnt4",  32'(cnt4),  ec(15));
    drive(1'b0, CMD_NOP, 32'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    check("clr_run_cnt32", cnt,       32'd0);
    check("clr_run_cnt4",  32'(cnt4), 32'd0);
    @(negedge clk);
    check("clr_run_inc32", cnt,       ec(1));
    check("clr_run_inc4",  32'(cnt4), ec(1));
    drive(1'b1, CMD_PAUSE, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 32'd0, 1'b0);
    check("final_pause_state", 32'(state4), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
